// File: rtl/vector_pkg.sv
// Shared definitions for the vector permute unit: function codes and the
// result FIFO entry layout.
package vector_pkg;

   localparam int unsigned VEC_DATA_WIDTH     = 32;
   localparam int unsigned VEC_LANES          = 16;
   localparam int unsigned VEC_REG_ADDR_WIDTH = 5;

   localparam logic [2:0] FUNC_SKEW      = 3'd0;
   localparam logic [2:0] FUNC_TRANSPOSE = 3'd1;

   // Entry is sized by the package widths; the pipe defaults its parameters to match.
   typedef struct packed {
      logic [VEC_LANES*VEC_DATA_WIDTH-1:0] vec;
      logic [VEC_REG_ADDR_WIDTH-1:0]       vd;
      logic                                err;
   } fifo_entry_t;

endpackage

// File: rtl/vector_permute.sv
// Combinational 3x3 permute: skew-symmetric matrix of lanes 0..2, or
// transpose of the 3x3 matrix in lanes 0..8. Unused lanes are zero.
module vector_permute
   import vector_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = VEC_DATA_WIDTH,
   parameter int unsigned VECTOR_LANES = VEC_LANES
) (
   input  logic [VECTOR_LANES*DATA_WIDTH-1:0] in_vec,
   input  logic [2:0]                         func,
   output logic [VECTOR_LANES*DATA_WIDTH-1:0] out_vec,
   output logic                               err
);

   logic [DATA_WIDTH-1:0] v0, v1, v2;
   logic [DATA_WIDTH-1:0] n0, n1, n2;

   assign v0 = in_vec[0*DATA_WIDTH +: DATA_WIDTH];
   assign v1 = in_vec[1*DATA_WIDTH +: DATA_WIDTH];
   assign v2 = in_vec[2*DATA_WIDTH +: DATA_WIDTH];

   // Sign-bit flip only, so -0.0 can appear and NaN payloads pass through.
   assign n0 = {~v0[DATA_WIDTH-1], v0[DATA_WIDTH-2:0]};
   assign n1 = {~v1[DATA_WIDTH-1], v1[DATA_WIDTH-2:0]};
   assign n2 = {~v2[DATA_WIDTH-1], v2[DATA_WIDTH-2:0]};

   always_comb begin
      out_vec = '0;
      err     = 1'b0;
      case (func)
         FUNC_SKEW: begin
            out_vec[1*DATA_WIDTH +: DATA_WIDTH] = v2;
            out_vec[2*DATA_WIDTH +: DATA_WIDTH] = n1;
            out_vec[3*DATA_WIDTH +: DATA_WIDTH] = n2;
            out_vec[5*DATA_WIDTH +: DATA_WIDTH] = v0;
            out_vec[6*DATA_WIDTH +: DATA_WIDTH] = v1;
            out_vec[7*DATA_WIDTH +: DATA_WIDTH] = n0;
         end
         FUNC_TRANSPOSE: begin
            for (int unsigned i = 0; i < 3; i++) begin
               for (int unsigned j = 0; j < 3; j++) begin
                  out_vec[(3*i+j)*DATA_WIDTH +: DATA_WIDTH] =
                     in_vec[(3*j+i)*DATA_WIDTH +: DATA_WIDTH];
               end
            end
         end
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/vector_permute_pipe.sv
// Flow-controlled permute execution stage: one operand register (s1), the
// combinational permute, and a small circular result FIFO toward writeback.
module vector_permute_pipe
   import vector_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = VEC_DATA_WIDTH,
   parameter int unsigned VECTOR_LANES   = VEC_LANES,
   parameter int unsigned REG_ADDR_WIDTH = VEC_REG_ADDR_WIDTH,
   parameter int unsigned FIFO_DEPTH     = 2
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [VECTOR_LANES*DATA_WIDTH-1:0] in_vec,
   input  logic [2:0]                         in_func,
   input  logic [REG_ADDR_WIDTH-1:0]          in_vd,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [VECTOR_LANES*DATA_WIDTH-1:0] out_vec,
   output logic [REG_ADDR_WIDTH-1:0]          out_vd,
   output logic                               out_err,
   output logic                               busy,
   output logic [15:0]                        op_count
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned VEC_W = VECTOR_LANES * DATA_WIDTH;

   logic [VEC_W-1:0]          s1_vec;
   logic [2:0]                s1_func;
   logic [REG_ADDR_WIDTH-1:0] s1_vd;
   logic                      s1_valid;

   logic [VEC_W-1:0] perm_vec;
   logic             perm_err;

   fifo_entry_t      mem [FIFO_DEPTH];
   fifo_entry_t      head;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   count;

   logic fifo_full, deq, s1_advance, accept;

   vector_permute #(
      .DATA_WIDTH   (DATA_WIDTH),
      .VECTOR_LANES (VECTOR_LANES)
   ) u_permute (
      .in_vec  (s1_vec),
      .func    (s1_func),
      .out_vec (perm_vec),
      .err     (perm_err)
   );

   assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
   assign out_valid  = (count != '0);
   assign deq        = out_valid && out_ready;
   // A dequeue frees a slot in the same cycle, so a full FIFO still lets s1 advance.
   assign s1_advance = s1_valid && (!fifo_full || deq);
   assign in_ready   = !s1_valid || s1_advance;
   assign accept     = in_valid && in_ready;
   assign busy       = s1_valid || out_valid;

   assign head     = mem[rd_ptr];
   assign out_vec  = out_valid ? head.vec : '0;
   assign out_vd   = out_valid ? head.vd  : '0;
   assign out_err  = out_valid ? head.err : 1'b0;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_vec   <= '0;
         s1_func  <= '0;
         s1_vd    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         op_count <= '0;
      end else begin
         s1_valid <= accept || (s1_valid && !s1_advance);
         if (accept) begin
            s1_vec  <= in_vec;
            s1_func <= in_func;
            s1_vd   <= in_vd;
         end
         if (s1_advance) wr_ptr <= wr_ptr + PTR_W'(1);
         if (deq)        rd_ptr <= rd_ptr + PTR_W'(1);
         case ({s1_advance, deq})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
         if (deq && op_count != 16'hFFFF) op_count <= op_count + 16'd1;
      end
   end

   // Storage needs no reset: out_* are masked by out_valid.
   always_ff @(posedge clk) begin
      if (!rst && s1_advance) begin
         mem[wr_ptr] <= '{vec: perm_vec, vd: s1_vd, err: perm_err};
      end
   end

endmodule

// File: tb/tb_vector_permute_pipe.sv
// Scoreboard bench for vector_permute_pipe: issue pushes hand-derived
// expectations, a negedge monitor pops and compares on every dequeue.
module tb_vector_permute_pipe;

   localparam int unsigned DW    = 32;
   localparam int unsigned LANES = 16;
   localparam int unsigned AW    = 5;
   localparam int unsigned VW    = DW * LANES;

   typedef struct {
      logic [VW-1:0] vec;
      logic [AW-1:0] vd;
      logic          err;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [VW-1:0] in_vec;
   logic [2:0]    in_func;
   logic [AW-1:0] in_vd;
   logic          out_valid;
   logic          out_ready;
   logic [VW-1:0] out_vec;
   logic [AW-1:0] out_vd;
   logic          out_err;
   logic          busy;
   logic [15:0]   op_count;

   int   pass_cnt  = 0;
   int   total_cnt = 0;
   exp_t sb [$];

   vector_permute_pipe #(
      .DATA_WIDTH     (DW),
      .VECTOR_LANES   (LANES),
      .REG_ADDR_WIDTH (AW),
      .FIFO_DEPTH     (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .in_func   (in_func),
      .in_vd     (in_vd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_vec   (out_vec),
      .out_vd    (out_vd),
      .out_err   (out_err),
      .busy      (busy),
      .op_count  (op_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %h required %h", name, got, exp);
   endtask

   // Monitor: a dequeue happens at the next posedge whenever out_valid && out_ready.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_output", 1'b1, 1'b0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("out_vec", out_vec, e.vec);
            check("out_vd", VW'(out_vd), VW'(e.vd));
            check("out_err", VW'(out_err), VW'(e.err));
         end
      end
   end

   function automatic logic [VW-1:0] lane_ramp(input logic [31:0] base);
      logic [VW-1:0] v;
      v = '0;
      for (int k = 0; k < 9; k++) v[k*DW +: DW] = base + 32'(k);
      return v;
   endfunction

   // Transposed ramp: output lane m holds input lane 3*(m%3) + m/3.
   function automatic logic [VW-1:0] ramp_transposed(input logic [31:0] base);
      logic [VW-1:0] v;
      v = '0;
      for (int m = 0; m < 9; m++) v[m*DW +: DW] = base + 32'(3*(m%3) + m/3);
      return v;
   endfunction

   // Called just after a posedge; returns after the accepting edge (+#1).
   task automatic issue(input logic [VW-1:0] v, input logic [2:0] f, input logic [AW-1:0] d,
                        input logic [VW-1:0] ev, input logic ee);
      bit done;
      in_valid = 1'b1; in_vec = v; in_func = f; in_vd = d;
      done = 0;
      for (int c = 0; c < 50 && !done; c++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back('{vec: ev, vd: d, err: ee});
            done = 1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!done) check("issue_timeout", 1'b0, 1'b1);
   endtask

   task automatic drain();
      bit done;
      done = 0;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         if (sb.size() == 0 && !busy) done = 1;
      end
      if (!done) check("drain_timeout", 1'b0, 1'b1);
      @(posedge clk); #1;
   endtask

   task automatic reset_check(input string tag);
      @(negedge clk);
      check({tag, "_out_valid"}, VW'(out_valid), '0);
      check({tag, "_busy"},      VW'(busy),      '0);
      check({tag, "_op_count"},  VW'(op_count),  '0);
      check({tag, "_in_ready"},  VW'(in_ready),  VW'(1));
      check({tag, "_out_vec"},   out_vec,        '0);
      check({tag, "_out_vd"},    VW'(out_vd),    '0);
      check({tag, "_out_err"},   VW'(out_err),   '0);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [VW-1:0] v, ev, held_vec;
      logic [AW-1:0] held_vd;
      int            accepted;
      bit            ready_dropped;

      rst = 1'b1; in_valid = 1'b0; in_vec = '0; in_func = '0; in_vd = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      reset_check("reset");

      // Skew of (1.0, 2.0, 3.0), plus first-result latency.
      v = '0;
      v[0*DW +: DW] = 32'h3F800000;
      v[1*DW +: DW] = 32'h40000000;
      v[2*DW +: DW] = 32'h40400000;
      v[5*DW +: DW] = 32'h12345678;
      ev = '0;
      ev[1*DW +: DW] = 32'h40400000;
      ev[2*DW +: DW] = 32'hC0000000;
      ev[3*DW +: DW] = 32'hC0400000;
      ev[5*DW +: DW] = 32'h3F800000;
      ev[6*DW +: DW] = 32'h40000000;
      ev[7*DW +: DW] = 32'hBF800000;
      issue(v, 3'd0, 5'd7, ev, 1'b0);
      @(negedge clk);
      check("latency_not_yet", VW'(out_valid), '0);
      @(negedge clk);
      check("latency_visible", VW'(out_valid), VW'(1));
      @(posedge clk); #1;
      drain();

      // Transpose of lane k = k with garbage in lanes 9..15.
      v = lane_ramp(0);
      for (int k = 9; k < 16; k++) v[k*DW +: DW] = 32'hFFFFFFFF;
      ev = '0;
      ev[1*DW +: DW] = 32'd3; ev[2*DW +: DW] = 32'd6; ev[3*DW +: DW] = 32'd1;
      ev[4*DW +: DW] = 32'd4; ev[5*DW +: DW] = 32'd7; ev[6*DW +: DW] = 32'd2;
      ev[7*DW +: DW] = 32'd5; ev[8*DW +: DW] = 32'd8;
      issue(v, 3'd1, 5'd3, ev, 1'b0);
      drain();

      // Illegal func then a legal op.
      issue(lane_ramp(32'h100), 3'd5, 5'd9, '0, 1'b1);
      issue(lane_ramp(32'h200), 3'd1, 5'd10, ramp_transposed(32'h200), 1'b0);
      drain();

      // Back-pressure: present vd 1..5 for 5 cycles with out_ready low.
      out_ready = 1'b0;
      accepted = 0;
      in_valid = 1'b1; in_func = 3'd1;
      for (int c = 0; c < 5; c++) begin
         in_vd  = AW'(accepted + 1);
         in_vec = lane_ramp(32'(16 * (accepted + 1)));
         @(negedge clk);
         if (in_ready) begin
            sb.push_back('{vec: ramp_transposed(32'(16 * (accepted + 1))),
                           vd: AW'(accepted + 1), err: 1'b0});
            accepted++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("bp_accepted", VW'(accepted), VW'(3));
      @(negedge clk);
      check("bp_in_ready_low", VW'(in_ready), '0);
      held_vec = out_vec; held_vd = out_vd;
      @(negedge clk);
      check("bp_vec_stable", out_vec, held_vec);
      check("bp_vd_stable", VW'(out_vd), VW'(held_vd));
      check("bp_head_vd", VW'(out_vd), VW'(1));
      @(posedge clk); #1;
      out_ready = 1'b1;
      issue(lane_ramp(32'd64), 3'd1, 5'd4, ramp_transposed(32'd64), 1'b0);
      issue(lane_ramp(32'd80), 3'd1, 5'd5, ramp_transposed(32'd80), 1'b0);
      drain();

      // Reset mid-operation with FIFO full and s1 valid.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         issue(lane_ramp(32'(i)), 3'd0, AW'(20 + i), '0, 1'b0);
      @(negedge clk);
      check("pre_reset_full", VW'({out_valid, in_ready, busy}), VW'(3'b101));
      @(posedge clk); #1;
      rst = 1'b1;
      sb.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      reset_check("midreset");
      out_ready = 1'b1;
      issue(lane_ramp(32'h300), 3'd1, 5'd11, ramp_transposed(32'h300), 1'b0);
      drain();

      // Streaming: 20 back-to-back from a fresh reset.
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      ready_dropped = 0;
      in_valid = 1'b1; in_func = 3'd1;
      for (int i = 0; i < 20; i++) begin
         in_vd  = AW'(i);
         in_vec = lane_ramp(32'(1000 + 10 * i));
         @(negedge clk);
         if (!in_ready) ready_dropped = 1;
         else sb.push_back('{vec: ramp_transposed(32'(1000 + 10 * i)), vd: AW'(i), err: 1'b0});
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("stream_in_ready_held", VW'(ready_dropped), '0);
      drain();
      check("stream_op_count", VW'(op_count), VW'(20));

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
